// File: rtl/u_scaled_addsub_n.sv
// u_scaled_addsub_n: N-input unary scaled adder/subtractor with residual accumulator.
// Density out is sum/NCH (mode 0) or saturating sum (mode 1); residual clamps with a sticky overflow.
module u_scaled_addsub_n #(
    parameter int NCH  = 4,
    parameter int ACCW = 4
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iEn,
    input  logic            iClr,
    input  logic            iMode,
    input  logic [NCH-1:0]  iNeg,
    input  logic [NCH-1:0]  iBits,
    output logic            oC,
    output logic [ACCW-1:0] oAcc,
    output logic            oOvf
);
    localparam logic [ACCW:0] NCHW = (ACCW+1)'(NCH);
    localparam logic [ACCW:0] MAXW = {1'b0, {ACCW{1'b1}}};
    localparam logic [ACCW:0] ONE  = (ACCW+1)'(1);

    logic [NCH-1:0] x;
    logic [ACCW:0]  cnt, sum, nxt;
    logic           hit, clamp;

    always_comb begin
        x = iBits ^ iNeg;
        cnt = '0;
        for (int i = 0; i < NCH; i++)
            cnt = cnt + (ACCW+1)'(x[i]);
        sum = {1'b0, oAcc} + cnt;
        hit = iMode ? (sum != '0) : (sum >= NCHW);
        nxt = iMode ? (hit ? sum - ONE : '0) : (hit ? sum - NCHW : sum);
        clamp = nxt > MAXW;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oC   <= 1'b0;
            oAcc <= '0;
            oOvf <= 1'b0;
        end else if (iClr) begin
            oC   <= 1'b0;
            oAcc <= '0;
            oOvf <= 1'b0;
        end else if (iEn) begin
            oC   <= hit;
            oAcc <= clamp ? MAXW[ACCW-1:0] : nxt[ACCW-1:0];
            oOvf <= oOvf | clamp;
        end else begin
            oC   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_u_scaled_addsub_n.sv
// tb_u_scaled_addsub_n: directed + random checks against an arithmetic model and a legacy 2-input golden.
module tb_u_scaled_addsub_n;
    logic       iClk = 0, iRstN = 0;
    logic       en = 0, clr = 0, mode = 0;
    logic [3:0] neg = 0, bits = 0;
    logic       oC, oOvf;
    logic [3:0] oAcc;
    logic       en2 = 0;
    logic [1:0] bits2 = 0;
    logic       c2, ovf2;
    logic [1:0] acc2;
    int tests = 0, fails = 0;
    int m_acc = 0;
    bit m_c = 0, m_ovf = 0;

    always #5 iClk = ~iClk;

    u_scaled_addsub_n #(.NCH(4), .ACCW(4)) dut (
        .iClk(iClk), .iRstN(iRstN), .iEn(en), .iClr(clr), .iMode(mode),
        .iNeg(neg), .iBits(bits), .oC(oC), .oAcc(oAcc), .oOvf(oOvf));

    u_scaled_addsub_n #(.NCH(2), .ACCW(2)) dut2 (
        .iClk(iClk), .iRstN(iRstN), .iEn(en2), .iClr(1'b0), .iMode(1'b0),
        .iNeg(2'b10), .iBits(bits2), .oC(c2), .oAcc(acc2), .oOvf(ovf2));

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got {c,acc,ovf}=%h expected %h", tag, got, exp);
        end
    endtask

    // Reference: apply the per-edge rules with plain integers
    task automatic mdl();
        int s, nx;
        if (clr) begin
            m_acc = 0; m_c = 0; m_ovf = 0;
        end else if (en) begin
            s = m_acc + $countones(bits ^ neg);
            if (!mode) begin
                m_c = (s >= 4);
                nx = m_c ? s - 4 : s;
            end else begin
                m_c = (s >= 1);
                nx = m_c ? s - 1 : 0;
            end
            if (nx > 15) begin m_acc = 15; m_ovf = 1; end
            else m_acc = nx;
        end else m_c = 0;
    endtask

    task automatic step(input string tag);
        logic [3:0] a;
        @(posedge iClk);
        mdl();
        #1;
        a = 4'(m_acc);
        chk(tag, {oC, oAcc, oOvf}, {m_c, a, m_ovf});
    endtask

    initial begin
        int ones, sumcnt, lacc, s;
        logic a, b, lo;
        #3;
        chk("reset", {oC, oAcc, oOvf}, 6'b0);
        #9 iRstN = 1;
        en = 1;
        bits = 4'hF;
        for (int i = 0; i < 8; i++) step("all_ones_m0");
        chk("all_ones_const", {oC, oAcc, oOvf}, {1'b1, 4'd0, 1'b0});
        bits = 4'b0001;
        for (int i = 0; i < 9; i++) step("quarter_m0");
        chk("quarter_const", {oC, oAcc, oOvf}, {1'b0, 4'd1, 1'b0});
        clr = 1; step("clr");
        clr = 0; mode = 1; bits = 4'hF;
        for (int i = 0; i < 5; i++) step("m1_ramp");
        chk("m1_no_ovf_yet", {oC, oAcc, oOvf}, {1'b1, 4'd15, 1'b0});
        step("m1_ovf");
        chk("m1_ovf_const", {oC, oAcc, oOvf}, {1'b1, 4'd15, 1'b1});
        step("m1_sat");
        clr = 1; mode = 0; bits = 4'b0001;
        step("clr_with_en");
        chk("clr_const", {oC, oAcc, oOvf}, 6'b0);
        clr = 0;
        for (int i = 0; i < 3; i++) step("build3");
        en = 0;
        for (int i = 0; i < 3; i++) step("hold");
        chk("hold_const", {oC, oAcc, oOvf}, {1'b0, 4'd3, 1'b0});
        en = 1; clr = 1; step("clr2");
        clr = 0; mode = 1; bits = 4'hF;
        for (int i = 0; i < 4; i++) step("build12");
        chk("acc12", {oC, oAcc, oOvf}, {1'b1, 4'd12, 1'b0});
        mode = 0; bits = 4'h0;
        for (int i = 0; i < 4; i++) step("drain");
        chk("drained", {oC, oAcc, oOvf}, 6'b0);
        bits = 4'b0111;
        for (int i = 0; i < 3; i++) step("prerst");
        #2 iRstN = 0;
        #1 chk("async_rst", {oC, oAcc, oOvf}, 6'b0);
        m_acc = 0; m_c = 0; m_ovf = 0;
        #2 iRstN = 1;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(7) != 0);
            clr = ($urandom_range(31) == 0);
            mode = ($urandom_range(3) == 0);
            neg = 4'($urandom);
            bits = 4'($urandom);
            step("random");
        end
        // Legacy 2-input scaled subtractor: density (A + (1-B))/2
        en = 0; en2 = 1;
        ones = 0; sumcnt = 0; lacc = 0;
        for (int i = 0; i < 10000; i++) begin
            a = ($urandom_range(3) != 0);
            b = ($urandom_range(3) == 0);
            bits2 = {b, a};
            @(posedge iClk);
            s = lacc + int'(a) + (1 - int'(b));
            sumcnt += int'(a) + (1 - int'(b));
            lo = (s >= 2);
            lacc = lo ? s - 2 : s;
            ones += int'(lo);
            #1;
            chk("legacy", {1'b0, c2, 2'b0, acc2, ovf2}, {1'b0, lo, 2'b0, 2'(lacc), 1'b0});
        end
        tests++;
        assert (ones * 2 === sumcnt - int'(acc2)) else begin
            fails++;
            $error("FAIL conservation: got ones*2=%0d expected %0d", ones * 2, sumcnt - int'(acc2));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/u_scaled_addsub_n.md
# u_scaled_addsub_n

Parametrised N-input unary scaled adder/subtractor for the scaler_SFFT stochastic datapath. It is the multi-channel successor of the 2-input scaled subtractor. Each cycle it inverts the input bits selected by a per-channel negate mask, counts the resulting ones, and accumulates the count into a residual register. It emits a registered output bitstream whose density is the sum divided by NCH (scaled mode) or the saturating unscaled sum (unscaled mode). It sits between butterfly operand streams and the next scaling stage.

## Interface
- NCH, default 4: number of input channels, ≥2.
- ACCW, default 4: residual register width; must satisfy 2^ACCW ≥ 2·NCH.
- iClk in 1: clock, rising edge.
- iRstN in 1: reset, asynchronous, active-low.
- iEn in 1: accumulate enable.
- iClr in 1: synchronous clear of all state.
- iMode in 1: 0 = scaled (÷NCH), 1 = unscaled saturating.
- iNeg in NCH: per-channel invert mask. A set bit makes that channel subtract in bipolar encoding.
- iBits in NCH: input stochastic bits, one per channel.
- oC out 1: output stochastic bit, registered.
- oAcc out ACCW: current residual register value.
- oOvf out 1: sticky flag, set when the residual is clamped.

## Operation
- Per cycle: x[i] = iBits[i] ^ iNeg[i]; cnt = popcount(x), range 0..NCH; sum = acc + cnt, computed at ACCW+1 bits.
- Mode 0 (scaled):
  - If sum ≥ NCH: oC ← 1, acc ← sum − NCH.
  - Else: oC ← 0, acc ← sum.
  - At most one NCH is subtracted per cycle.
- Mode 1 (unscaled):
  - If sum ≥ 1: oC ← 1, next = sum − 1.
  - Else: oC ← 0, next = 0.
- Clamp (both modes): if next > 2^ACCW−1, acc ← 2^ACCW−1 and oOvf ← 1. Otherwise acc ← next.
- Equivalence: NCH=2, iNeg=2'b10, iMode=0 reproduces the legacy 2-input scaled subtractor bit-for-bit, giving density (A + (1−B))/2.
- Priority per edge: iRstN low > iClr > iEn.
  - iClr=1: acc ← 0, oC ← 0, oOvf ← 0.
  - iEn=0, iClr=0: acc holds, oC ← 0, oOvf holds.
- Mode change: takes effect on the next edge. The residual is carried over, not cleared. If acc ≥ NCH on entering mode 0, it drains by NCH per cycle through the normal rule.
- Conservation, mode 0, no clamp: total oC ones over a run = (Σcnt − acc_final + acc_initial) / NCH, exactly.
- oOvf is cleared only by reset or iClr.

## Timing
- Reset values: oC = 0, oAcc = 0, oOvf = 0, asynchronous on the iRstN falling edge.
- Latency: inputs sampled at edge k appear on oC/oAcc/oOvf after edge k. This is 1 cycle; outputs are registered with no combinational input-to-output path.
- Throughput: one input vector per cycle; no stall or back-pressure.
- Reset deassertion: the first accumulation occurs at the first rising edge with iRstN high.
- Reset mid-stream: residual and flags are lost immediately; no partial output.
- Simultaneous iClr and iEn: the clear wins, and that cycle's input vector is discarded.
- Changes to iNeg, iMode, iBits take effect at the next edge; no internal sequencing is required.

## Test plan
- NCH=4, ACCW=4, mode 0, iNeg=0, iBits=4'hF for 8 cycles -> oC=1 after every edge, oAcc=0 throughout.
- Mode 0, iBits=4'b0001 constant -> oAcc sequence 1,2,3,0,1…; oC=1 only on every 4th edge; 25% density.
- NCH=2, iNeg=2'b10, random iA/iB at p=0.75/0.25 for 10000 cycles -> ones = (Σcnt − acc_final)/2 exactly. The result must be bit-identical to a golden model of the legacy subtractor.
- Mode 1, iBits=4'hF, 8 cycles -> oAcc 3,6,9,12,15,15…; oOvf rises after the 6th edge (sum−1 = 18 > 15); oC=1 throughout.
- Control overrides:
  - acc=3 with iEn=0 for 3 cycles -> oAcc holds 3, oC=0.
  - iClr with iEn=1 -> oAcc=0, oOvf=0, oC=0.
  - iRstN pulse mid-stream -> all outputs are 0 immediately, before any clock edge.
- Mode switch: build acc=12 in mode 1, then set iMode=0 with iBits=0 -> oAcc 8,4,0, oC 1,1,1, then oC=0.
